// File: rtl/idct1d_pipe_if.sv
// Block-level stream bundle for idct1d_pipe: coefficient input channel, sample
// output channel and the delivered-block counter.
interface idct1d_pipe_if #(
  parameter int N = 16
) ();
  logic           in_valid;
  logic           in_ready;
  logic [8*N-1:0] data_in;
  logic           out_valid;
  logic           out_ready;
  logic [8*N-1:0] data_out;
  logic [15:0]    blk_count;

  // master is the environment (coefficient source + sample sink), slave is the transform.
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, blk_count
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, blk_count
  );
endinterface

// File: rtl/idct1d_pipe.sv
// Eight-point 1-D inverse DCT: products -> even/odd butterflies -> combine, round, saturate.
// Three pipeline stages under a single global stall; adders optionally approximate.
module idct1d_pipe #(
  parameter int N      = 16,
  parameter int F      = 12,
  parameter int APPROX = 0
) (
  input logic          clk,
  input logic          reset,
  idct1d_pipe_if.slave bus
);

  localparam int PW = N + F + 1;  // product width
  localparam int SW = N + F + 4;  // butterfly/sum width, headroom for eight products
  localparam int HL = N / 2;      // low part handled by the approximate adder

  localparam int C1I = $rtoi(0.490393 * (2.0 ** F) + 0.5);
  localparam int C2I = $rtoi(0.461940 * (2.0 ** F) + 0.5);
  localparam int C3I = $rtoi(0.415735 * (2.0 ** F) + 0.5);
  localparam int C4I = $rtoi(0.353553 * (2.0 ** F) + 0.5);
  localparam int C5I = $rtoi(0.277785 * (2.0 ** F) + 0.5);
  localparam int C6I = $rtoi(0.191342 * (2.0 ** F) + 0.5);
  localparam int C7I = $rtoi(0.097545 * (2.0 ** F) + 0.5);

  localparam logic signed [F:0] K1 = C1I[F:0];
  localparam logic signed [F:0] K2 = C2I[F:0];
  localparam logic signed [F:0] K3 = C3I[F:0];
  localparam logic signed [F:0] K4 = C4I[F:0];
  localparam logic signed [F:0] K5 = C5I[F:0];
  localparam logic signed [F:0] K6 = C6I[F:0];
  localparam logic signed [F:0] K7 = C7I[F:0];

  localparam logic signed [SW-1:0] RND     = {{(SW-F){1'b0}}, 1'b1, {(F-1){1'b0}}};
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

  function automatic logic signed [PW-1:0] f_mul(input logic signed [N-1:0] x,
                                                 input logic signed [F:0]   c);
    return PW'(x) * PW'(c);
  endfunction

  function automatic logic signed [SW-1:0] f_ext(input logic signed [PW-1:0] p);
    return SW'(p);
  endfunction

  function automatic logic signed [F:0] f_kodd(input int j);
    case (j)
      0:       return K1;
      1:       return K3;
      2:       return K5;
      default: return K7;
    endcase
  endfunction

  // Hybrid adder: OR-approximated low HL bits, carry-in to the exact high part from the low MSBs.
  function automatic logic signed [SW-1:0] f_add(input logic signed [SW-1:0] a,
                                                 input logic signed [SW-1:0] b,
                                                 input logic                 sub);
    logic signed [SW-1:0] bb;
    logic        [SW-1:0] r;
    bb = sub ? -b : b;
    if (APPROX == 0) begin
      r = a + bb;
    end else begin
      r[HL-1:0]  = a[HL-1:0] | bb[HL-1:0];
      r[SW-1:HL] = a[SW-1:HL] + bb[SW-1:HL] + {{(SW-HL-1){1'b0}}, a[HL-1] & bb[HL-1]};
    end
    return r;
  endfunction

  function automatic logic [N-1:0] f_round_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = (v + RND) >>> F;
    if (t > SAT_MAX)      return SAT_MAX[N-1:0];
    else if (t < SAT_MIN) return SAT_MIN[N-1:0];
    else                  return t[N-1:0];
  endfunction

  logic                 w_advance;
  logic signed [N-1:0]  w_x  [8];
  logic                 r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [PW-1:0] r_pe [6];     // X0C4, X4C4, X2C2, X6C6, X2C6, X6C2
  logic signed [PW-1:0] r_po [4][4];  // [X1,X3,X5,X7][C1,C3,C5,C7]
  logic signed [SW-1:0] w_a0, w_a1, w_b0, w_b1;
  logic signed [SW-1:0] w_oa [4];
  logic signed [SW-1:0] w_ob [4];
  logic signed [SW-1:0] w_e  [4];
  logic signed [SW-1:0] w_o  [4];
  logic signed [SW-1:0] r_e  [4];
  logic signed [SW-1:0] r_o  [4];
  logic [8*N-1:0]       w_pack;
  logic [8*N-1:0]       r_data_out;
  logic [15:0]          r_blk_count;

  assign w_advance     = ~r_s3_valid | bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_s3_valid;
  assign bus.data_out  = r_data_out;
  assign bus.blk_count = r_blk_count;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_x[k] = bus.data_in[(7-k)*N +: N];
    end
  end

  // Even half from k=0,2,4,6 and odd half from k=1,3,5,7, full precision.
  always_comb begin
    w_a0 = f_add(f_ext(r_pe[0]), f_ext(r_pe[1]), 1'b0);
    w_a1 = f_add(f_ext(r_pe[0]), f_ext(r_pe[1]), 1'b1);
    w_b0 = f_add(f_ext(r_pe[2]), f_ext(r_pe[3]), 1'b0);
    w_b1 = f_add(f_ext(r_pe[4]), f_ext(r_pe[5]), 1'b1);
    w_e[0] = f_add(w_a0, w_b0, 1'b0);
    w_e[1] = f_add(w_a1, w_b1, 1'b0);
    w_e[2] = f_add(w_a1, w_b1, 1'b1);
    w_e[3] = f_add(w_a0, w_b0, 1'b1);

    w_oa[0] = f_add(f_ext(r_po[0][0]), f_ext(r_po[1][1]), 1'b0);
    w_ob[0] = f_add(f_ext(r_po[2][2]), f_ext(r_po[3][3]), 1'b0);
    w_oa[1] = f_add(f_ext(r_po[0][1]), f_ext(r_po[1][3]), 1'b1);
    w_ob[1] = f_add(f_ext(r_po[2][0]), f_ext(r_po[3][2]), 1'b0);
    w_oa[2] = f_add(f_ext(r_po[0][2]), f_ext(r_po[1][0]), 1'b1);
    w_ob[2] = f_add(f_ext(r_po[2][3]), f_ext(r_po[3][1]), 1'b0);
    w_oa[3] = f_add(f_ext(r_po[0][3]), f_ext(r_po[1][2]), 1'b1);
    w_ob[3] = f_add(f_ext(r_po[2][1]), f_ext(r_po[3][0]), 1'b1);
    w_o[0]  = f_add(w_oa[0], w_ob[0], 1'b0);
    w_o[1]  = f_add(w_oa[1], w_ob[1], 1'b1);
    w_o[2]  = f_add(w_oa[2], w_ob[2], 1'b0);
    w_o[3]  = f_add(w_oa[3], w_ob[3], 1'b0);
  end

  always_comb begin
    w_pack = '0;
    for (int n = 0; n < 4; n++) begin
      w_pack[(7-n)*N +: N] = f_round_sat(f_add(r_e[n], r_o[n], 1'b0));
      w_pack[n*N +: N]     = f_round_sat(f_add(r_e[n], r_o[n], 1'b1));
    end
  end

  // NOTE: stage 1/2 datapath registers have no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_pe[0] <= f_mul(w_x[0], K4);
      r_pe[1] <= f_mul(w_x[4], K4);
      r_pe[2] <= f_mul(w_x[2], K2);
      r_pe[3] <= f_mul(w_x[6], K6);
      r_pe[4] <= f_mul(w_x[2], K6);
      r_pe[5] <= f_mul(w_x[6], K2);
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_po[i][j] <= f_mul(w_x[2*i+1], f_kodd(j));
        end
      end
      for (int n = 0; n < 4; n++) begin
        r_e[n] <= w_e[n];
        r_o[n] <= w_o[n];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_data_out  <= '0;
      r_blk_count <= '0;
    end else begin
      if (w_advance) begin
        r_s1_valid <= bus.in_valid;
        r_s2_valid <= r_s1_valid;
        r_s3_valid <= r_s2_valid;
        r_data_out <= w_pack;
      end
      if (r_s3_valid && bus.out_ready) begin
        r_blk_count <= r_blk_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_idct1d_pipe.sv
// Self-checking bench for idct1d_pipe: exact instance against a cosine-table reference,
// approximate instance checked for identical handshaking with its error logged.
module tb_idct1d_pipe;

  localparam int  N  = 16;
  localparam int  F  = 12;
  localparam real PI = 3.14159265358979;

  typedef struct {
    logic [127:0] exp;
    logic [127:0] orig;
    bit           rt;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  idct1d_pipe_if #(.N(N)) bus   ();
  idct1d_pipe_if #(.N(N)) bus_a ();

  assign bus_a.in_valid  = bus.in_valid;
  assign bus_a.data_in   = bus.data_in;
  assign bus_a.out_ready = bus.out_ready;

  idct1d_pipe #(.N(N), .F(F), .APPROX(0)) dut   (.clk(clk), .reset(reset), .bus(bus.slave));
  idct1d_pipe #(.N(N), .F(F), .APPROX(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  int           errors = 0;
  int           checks = 0;
  int           exp_cnt = 0;
  int           approx_max_err = 0;
  bit [2:0]     tv = '0;
  item_t        q[$];
  logic [127:0] pend_orig = '0;
  bit           pend_rt = 1'b0;
  int           smp[8];
  int           ct[8] = '{1448, 2009, 1892, 1703, 1448, 1138, 784, 400};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // x[n] = sum_k Ck*X[k]*cos((2n+1)k*pi/16), cosine reduced to a signed table entry.
  function automatic logic [127:0] model(input logic [127:0] din);
    logic [127:0] r;
    longint acc, v, xk;
    int m, s;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        xk = longint'($signed(din[(7-k)*16 +: 16]));
        m  = ((2*n+1)*k) % 32;
        s  = 1;
        if (m > 16) m = 32 - m;
        if (m > 8) begin s = -1; m = 16 - m; end
        acc += longint'(s * ct[m]) * xk;
      end
      v = (acc + 2048) >>> 12;
      if (v > 32767)  v = 32767;
      if (v < -32768) v = -32768;
      r[(7-n)*16 +: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] fdct(input int s[8]);
    logic [127:0] r;
    real a;
    int xi;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      a = 0.0;
      for (int n = 0; n < 8; n++) a += real'(s[n]) * $cos(real'((2*n+1)*k) * PI / 16.0);
      a = a * ((k == 0) ? 0.5 / $sqrt(2.0) : 0.5);
      xi = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(-a + 0.5);
      r[(7-k)*16 +: 16] = xi[15:0];
    end
    return r;
  endfunction

  task automatic new_vec();
    for (int n = 0; n < 8; n++) smp[n] = int'($urandom_range(510)) - 255;
    bus.data_in = fdct(smp);
    for (int n = 0; n < 8; n++) pend_orig[(7-n)*16 +: 16] = smp[n][15:0];
    pend_rt = 1'b1;
  endtask

  // One clock: inputs already set at posedge+1; check handshake, score, advance.
  task automatic cycle(output bit in_fire);
    logic  exp_rdy;
    item_t it;
    bit    ok;
    int    d;
    #1;
    exp_rdy = !tv[2] || bus.out_ready;
    check("in_ready",         128'(bus.in_ready),    128'(exp_rdy));
    check("in_ready_approx",  128'(bus_a.in_ready),  128'(exp_rdy));
    check("out_valid",        128'(bus.out_valid),   128'(tv[2]));
    check("out_valid_approx", 128'(bus_a.out_valid), 128'(tv[2]));
    in_fire = bus.in_valid && bus.in_ready;
    if (in_fire) q.push_back('{model(bus.data_in), pend_orig, pend_rt});
    if (bus.out_valid && bus.out_ready) begin
      exp_cnt++;
      check("out_expected", 128'(q.size() != 0), 128'(1));
      if (q.size() != 0) begin
        it = q.pop_front();
        check("out_data", bus.data_out, it.exp);
        for (int n = 0; n < 8; n++) begin
          d = int'($signed(bus_a.data_out[(7-n)*16 +: 16])) - int'($signed(it.exp[(7-n)*16 +: 16]));
          if (d < 0) d = -d;
          if (d > approx_max_err) approx_max_err = d;
        end
        if (it.rt) begin
          ok = 1'b1;
          for (int n = 0; n < 8; n++) begin
            d = int'($signed(bus.data_out[(7-n)*16 +: 16])) - int'($signed(it.orig[(7-n)*16 +: 16]));
            if (d > 2 || d < -2) ok = 1'b0;
          end
          check("roundtrip", 128'(ok), 128'(1));
        end
      end
    end
    if (exp_rdy) tv = {tv[1], tv[0], bus.in_valid};
    @(posedge clk);
    #1;
  endtask

  task automatic dc_test(input string tag, input logic [15:0] x0, input logic [15:0] expv);
    bit f;
    bus.data_in   = {x0, 112'b0};
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    pend_rt       = 1'b0;
    cycle(f);
    check({tag, "_accept"}, 128'(f), 128'(1));
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 128'(bus.out_valid), 128'(0));
    cycle(f);
    check({tag, "_lat2"}, 128'(bus.out_valid), 128'(0));
    cycle(f);
    check({tag, "_lat3"}, 128'(bus.out_valid), 128'(1));
    check({tag, "_data"}, bus.data_out, {8{expv}});
    cycle(f);
    check({tag, "_blk_count"}, 128'(bus.blk_count), 128'(exp_cnt[15:0]));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit           f;
    int           acc;
    logic [127:0] blk[4];
    logic [127:0] held;

    // Reset state
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_data_out",  bus.data_out,        128'(0));
    check("rst_blk_count", 128'(bus.blk_count), 128'(0));
    check("rst_in_ready",  128'(bus.in_ready),  128'(1));
    reset = 1'b0;

    // DC, negative DC, saturation/sign pattern
    dc_test("dc_pos", 16'sd1000, 16'd354);
    dc_test("dc_neg", -16'sd1000, -16'sd354);

    bus.data_in  = {8{16'h7FFF}};
    bus.in_valid = 1'b1;
    cycle(f);
    bus.in_valid = 1'b0;
    cycle(f);
    cycle(f);
    check("sat_x0", 128'(bus.data_out[127:112]), 128'(16'h7FFF));
    check("sat_x7", 128'(bus.data_out[15:0]),    128'(16'd2576));
    cycle(f);

    // Backpressure: sink stalled, four distinct blocks offered
    for (int i = 0; i < 4; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.data_in  = blk[(acc < 4) ? acc : 3];
      bus.in_valid = 1'b1;
      cycle(f);
      if (f) acc++;
    end
    check("bp_accepted", 128'(acc), 128'(3));
    check("bp_in_ready", 128'(bus.in_ready), 128'(0));
    check("bp_hold", bus.data_out, model(blk[0]));
    held = bus.data_out;
    cycle(f);
    check("bp_stable", bus.data_out, held);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.data_in  = blk[(acc < 4) ? acc : 3];
      bus.in_valid = (acc < 4);
      cycle(f);
      if (f) acc++;
      if (acc >= 4 && q.size() == 0) break;
    end
    check("bp_all_in",    128'(acc),        128'(4));
    check("bp_drained",   128'(q.size()),   128'(0));
    check("bp_blk_count", 128'(bus.blk_count), 128'(exp_cnt[15:0]));

    // Reset mid-stream with two blocks in flight
    for (int i = 0; i < 2; i++) begin
      bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid = 1'b1;
      cycle(f);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("mid_rst_data_out",  bus.data_out,        128'(0));
    check("mid_rst_blk_count", 128'(bus.blk_count), 128'(0));
    check("mid_rst_in_ready",  128'(bus.in_ready),  128'(1));
    @(posedge clk);
    #1;
    check("mid_rst_hold_valid", 128'(bus.out_valid), 128'(0));
    reset = 1'b0;
    q.delete();
    tv      = '0;
    exp_cnt = 0;
    dc_test("dc_after_rst", 16'sd1000, 16'd354);

    // Random round-trip stream with random stalls on both sides
    acc = 0;
    new_vec();
    for (int c = 0; c < 600 && acc < 40; c++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(3) != 0);
      cycle(f);
      if (f) begin
        acc++;
        new_vec();
      end
    end
    check("rand_sent", 128'(acc), 128'(40));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle(f);
    check("rand_drained",          128'(q.size()),          128'(0));
    check("rand_blk_count",        128'(bus.blk_count),     128'(exp_cnt[15:0]));
    check("rand_blk_count_approx", 128'(bus_a.blk_count),   128'(exp_cnt[15:0]));

    $display("approx adder max abs output error vs exact: %0d", approx_max_err);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idct1d_pipe.md
# idct1d_pipe

Eight-point one-dimensional inverse DCT, the decode-side counterpart of the forward `dct1d` butterfly. It takes one block of eight signed frequency coefficients in the same packed order the forward transform produces and returns eight signed spatial samples. The datapath is a 3-stage pipeline with valid/ready handshakes on both sides, so it can sit directly behind a coefficient buffer and ahead of a sample sink that may stall. Adders are selectable between exact and `HybridAdder` approximate instances, which lets the block be used for approximate-adder error studies.

## Interface
- `N`, 16: width of each coefficient and sample (signed, two's complement).
- `F`, 12: fractional bits of the fixed-point cosine constants.
- `APPROX`, 0: 0 selects exact adders; 1 selects `HybridAdder` (N1=N/2, N2=N/2) for every add/subtract.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `data_in` holds a coefficient block.
- `in_ready` output 1: block accepts a block this cycle.
- `data_in` input 8*N: {X0,X1,…,X7}, X0 in the MSBs.
- `out_valid` output 1: `data_out` holds a sample block.
- `out_ready` input 1: sink accepts a block this cycle.
- `data_out` output 8*N: {x0,x1,…,x7}, x0 in the MSBs.
- `blk_count` output 16: number of blocks delivered since reset, modulo 2^16.

## Operation
- Constants, Q(F) integers, F=12: C0=C4=1448, C1=2009, C2=1892, C3=1703, C5=1138, C6=784, C7=400. For other F values: round(value·2^F) of 0.353553, 0.490393, 0.461940, 0.415735, 0.277785, 0.191342, 0.097545.
- Transform: x[n] = Σk Ck·X[k]·sgn/cos pattern, i.e. Ck·X[k] weighted by cos((2n+1)kπ/16) normalised so that Ck already includes the 0.5·C(k) factor (C0 for k=0, C4 used for the DC term).
- Stage 1 registers all products Ck·X[k] at full width (N+F+1 bits, signed). No truncation.
- Stage 2 forms the even part e[n] from k=0,2,4,6 and the odd part o[n] from k=1,3,5,7 for n=0..3, at full precision.
- Stage 3 computes x[n]=e[n]+o[n] and x[7−n]=e[n]−o[n]. It then rounds once: add 2^(F−1) and arithmetic-shift right by F. It then saturates to the N-bit signed range [−2^(N−1), 2^(N−1)−1].
- With APPROX=0 the result must be bit-exact with this definition. With APPROX=1 only the adders change; the product, rounding and saturation rules are unchanged.
- `blk_count` increments by 1 on each output handshake (`out_valid`&&`out_ready`) and wraps from 0xFFFF to 0.

## Timing
- Global stall: advance = ~s3_valid | out_ready, and `in_ready` = advance.
- When advance is high, every stage shifts one place (including bubbles), and s1_valid takes `in_valid`.
- When advance is low, all stage registers and valids hold.
- Input handshake (`in_valid`&&`in_ready`): the block appears on `data_out` with `out_valid`=1 exactly 3 cycles later if unstalled.
- Throughput: 1 block per cycle while `out_ready`=1.
- `out_valid`=s3_valid, and `data_out` is registered. `data_out` must stay stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is combinational from `out_ready`; `out_valid` does not depend combinationally on `in_valid`.
- `out_valid` may rise independently of `out_ready`.
- Reset, asserted at any time including mid-stream:
  - All stage valids go to 0, so `out_valid`=0.
  - `data_out`=0 and `blk_count`=0.
  - `in_ready`=1 while reset is held.
  - In-flight blocks are discarded.
  - Operation restarts on the first clock edge after reset deasserts.
- Simultaneous input and output handshake in one cycle: both complete; the pipeline shifts.

## Test plan
- DC only: N=16, F=12, APPROX=0, X0=1000, others 0 -> `out_valid` 3 cycles after accept; all eight outputs = 354; `blk_count`=1.
- Negative DC: X0=−1000, others 0 -> all eight outputs = −354.
- Saturation and sign pattern: all X[k]=32767 -> x0=32767 (saturated), x7=2576.
- Backpressure: `out_ready`=0, `in_valid`=1 with four distinct blocks -> exactly 3 accepted and `in_ready`=0 afterwards; `data_out` holds block 1 stable. Raising `out_ready` then delivers blocks 1–4 in order, one per cycle, with no loss or duplication.
- Reset mid-stream: assert `reset` asynchronously between clock edges with 2 blocks in flight -> `out_valid`, `data_out` and `blk_count` go to 0 immediately. After release, a new DC block yields 354s after 3 cycles.
- Round trip: forward-transform random 8-sample vectors in the range ±255, then pass them through the block -> each output within ±2 of the original with APPROX=0. With APPROX=1, log the error for comparison; the handshake must behave identically.
